// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared opcode/funct constants, control-bundle bit indices and md_unit FSM states
package rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUSRC   = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    function automatic logic is_mop(input logic [31:0] instr);
        return (instr[6:0] == OPC_OP) && (instr[31:25] == F7_MULDIV);
    endfunction

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative 32-step shift-add multiplier / restoring divider
// Works on magnitudes; signs are reapplied when the result is read out in DONE.
module md_unit
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);
    md_state_t   r_state, w_next;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic        r_a_neg, r_b_neg, r_b_zero;
    logic [31:0] r_a_orig;
    logic [63:0] r_acc, r_mcand;
    logic [31:0] r_mplier, r_quo, r_rem, r_dvs;

    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_quo, w_rem;
    logic [32:0] w_trial, w_diff;
    logic [63:0] w_prod;

    assign w_a_neg = i_a[31] && (i_op == F3_MULH || i_op == F3_MULHSU || i_op == F3_DIV || i_op == F3_REM);
    assign w_b_neg = i_b[31] && (i_op == F3_MULH || i_op == F3_DIV || i_op == F3_REM);
    assign w_a_mag = w_a_neg ? 32'd0 - i_a : i_a;
    assign w_b_mag = w_b_neg ? 32'd0 - i_b : i_b;
    assign w_trial = {r_rem, r_quo[31]};
    assign w_diff  = w_trial - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_CALC;
            ST_CALC: begin
                o_busy = 1'b1;
                if (r_cnt == 5'd31) w_next = ST_DONE;
            end
            ST_DONE: begin
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_op     <= 3'd0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_orig <= 32'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_dvs    <= 32'd0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_cnt    <= 5'd0;
            r_op     <= i_op;
            r_a_neg  <= w_a_neg;
            r_b_neg  <= w_b_neg;
            r_b_zero <= (i_b == 32'd0);
            r_a_orig <= i_a;
            r_acc    <= 64'd0;
            r_mcand  <= {32'd0, w_a_mag};
            r_mplier <= w_b_mag;
            r_quo    <= w_a_mag;
            r_rem    <= 32'd0;
            r_dvs    <= w_b_mag;
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_op[2]) begin
                r_quo <= {r_quo[30:0], ~w_diff[32]};
                r_rem <= w_diff[32] ? w_trial[31:0] : w_diff[31:0];
            end else begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end

    // Divide-by-zero bypasses the sign fixup; INT_MIN/-1 falls out naturally.
    assign w_prod = (r_a_neg ^ r_b_neg) ? 64'd0 - r_acc : r_acc;
    assign w_quo  = (r_a_neg ^ r_b_neg) ? 32'd0 - r_quo : r_quo;
    assign w_rem  = r_a_neg ? 32'd0 - r_rem : r_rem;

    always_comb begin
        o_result = w_prod[31:0];
        case (r_op)
            F3_MUL:                        o_result = w_prod[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  o_result = w_prod[63:32];
            F3_DIV, F3_DIVU:               o_result = r_b_zero ? 32'hFFFF_FFFF : w_quo;
            default:                       o_result = r_b_zero ? r_a_orig : w_rem;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: single-cycle ALU plus iterative M-extension via md_unit
module execute_stage
    import rv_pkg::*;
(
    input  logic               clk2,
    input  logic               rst,
    input  logic signed [31:0] RD1,
    input  logic signed [31:0] RD2,
    input  logic signed [31:0] Imm_Ext,
    input  logic        [31:0] RD_Instr,
    input  logic        [7:0]  contrl_sig,
    output logic signed [31:0] ALUResult,
    output logic signed [31:0] RD2_Top,
    output logic        [31:0] next_IR,
    output logic        [7:0]  ctrl_sig,
    output logic               busy
);
    logic [6:0]         w_opcode, w_f7;
    logic [2:0]         w_f3;
    logic signed [31:0] w_b, w_alu;
    logic [4:0]         w_shamt;
    logic               w_start, w_md_busy, w_md_done;
    logic [31:0]        w_md_result;
    logic [31:0]        r_ir, r_rd2;
    logic [7:0]         r_ctrl;

    assign w_opcode = RD_Instr[6:0];
    assign w_f3     = RD_Instr[14:12];
    assign w_f7     = RD_Instr[31:25];
    assign w_b      = contrl_sig[CTRL_ALUSRC] ? Imm_Ext : RD2;
    assign w_shamt  = w_b[4:0];

    // Only accept a new M-op when md_unit is fully idle (not in CALC or DONE).
    assign w_start = is_mop(RD_Instr) && !w_md_busy && !w_md_done;
    assign busy    = w_start || w_md_busy;

    always_comb begin
        w_alu = RD1 + w_b;
        case (w_opcode)
            OPC_LOAD, OPC_STORE: w_alu = RD1 + Imm_Ext;
            OPC_OP, OPC_OPIMM: begin
                case (w_f3)
                    F3_ADD:  w_alu = (w_opcode == OPC_OP && w_f7 == F7_ALT) ? RD1 - w_b : RD1 + w_b;
                    F3_SLL:  w_alu = RD1 << w_shamt;
                    F3_SLT:  w_alu = {31'd0, RD1 < w_b};
                    F3_SLTU: w_alu = {31'd0, $unsigned(RD1) < $unsigned(w_b)};
                    F3_XOR:  w_alu = RD1 ^ w_b;
                    F3_SR:   w_alu = w_f7[5] ? RD1 >>> w_shamt : RD1 >> w_shamt;
                    F3_OR:   w_alu = RD1 | w_b;
                    default: w_alu = RD1 & w_b;
                endcase
            end
            default: w_alu = RD1 + w_b;
        endcase
    end

    md_unit u_md (
        .clk      (clk2),
        .rst      (rst),
        .i_start  (w_start),
        .i_op     (w_f3),
        .i_a      (RD1),
        .i_b      (RD2),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    always_ff @(posedge clk2) begin
        if (rst) begin
            ALUResult <= 32'sd0;
            RD2_Top   <= 32'sd0;
            next_IR   <= 32'd0;
            ctrl_sig  <= 8'd0;
            r_ir      <= 32'd0;
            r_rd2     <= 32'd0;
            r_ctrl    <= 8'd0;
        end else if (w_md_done) begin
            ALUResult <= w_md_result;
            RD2_Top   <= r_rd2;
            next_IR   <= r_ir;
            ctrl_sig  <= r_ctrl;
        end else if (w_md_busy) begin
            ctrl_sig  <= 8'd0;
        end else if (w_start) begin
            ctrl_sig  <= 8'd0;
            r_ir      <= RD_Instr;
            r_rd2     <= RD2;
            r_ctrl    <= contrl_sig;
        end else begin
            ALUResult <= w_alu;
            RD2_Top   <= RD2;
            next_IR   <= RD_Instr;
            ctrl_sig  <= contrl_sig;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;
    logic               clk2 = 1'b0;
    logic               rst;
    logic signed [31:0] RD1, RD2, Imm_Ext;
    logic        [31:0] RD_Instr;
    logic        [7:0]  contrl_sig;
    logic signed [31:0] ALUResult, RD2_Top;
    logic        [31:0] next_IR;
    logic        [7:0]  ctrl_sig;
    logic               busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] a, b, imm;
        logic [7:0]  ctl;
        logic [31:0] exp;
    } vec_t;

    execute_stage dut (
        .clk2(clk2), .rst(rst), .RD1(RD1), .RD2(RD2), .Imm_Ext(Imm_Ext),
        .RD_Instr(RD_Instr), .contrl_sig(contrl_sig), .ALUResult(ALUResult),
        .RD2_Top(RD2_Top), .next_IR(next_IR), .ctrl_sig(ctrl_sig), .busy(busy)
    );

    always #5 clk2 = ~clk2;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic set_nop();
        RD_Instr = mk(7'd0, 3'b000, 7'b0010011);
        RD1 = 0; RD2 = 0; Imm_Ext = 0; contrl_sig = 8'h02;
    endtask

    task automatic test_reset();
        RD_Instr = mk(7'd0, 3'b000, 7'b0110011);
        RD1 = 3; RD2 = 4; Imm_Ext = 9; contrl_sig = 8'hA5;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ALUResult !== 32'sd0) begin errors++; $display("FAIL reset_alu got %h want 0", ALUResult); end
        checks++; if (RD2_Top !== 32'sd0) begin errors++; $display("FAIL reset_rd2 got %h want 0", RD2_Top); end
        checks++; if (next_IR !== 32'd0) begin errors++; $display("FAIL reset_ir got %h want 0", next_IR); end
        checks++; if (ctrl_sig !== 8'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl_sig); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        RD_Instr = mk(7'd0, 3'b000, 7'b0110011);
        RD1 = 5; RD2 = -7; Imm_Ext = 100; contrl_sig = 8'h00;
        tick();
        checks++; if (ALUResult !== -32'sd2) begin errors++; $display("FAIL add got %h want fffffffe", ALUResult); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy got %b want 0", busy); end
    endtask

    task automatic test_alu_ops();
        vec_t v[11];
        v[0]  = '{"sub",  mk(7'b0100000, 3'b000, 7'b0110011), 32'd10, 32'd3, 32'd0, 8'h00, 32'd7};
        v[1]  = '{"sll",  mk(7'b0000000, 3'b001, 7'b0110011), 32'd1, 32'd33, 32'd0, 8'h00, 32'd2};
        v[2]  = '{"sra",  mk(7'b0100000, 3'b101, 7'b0110011), 32'h80000000, 32'd4, 32'd0, 8'h00, 32'hF8000000};
        v[3]  = '{"srl",  mk(7'b0000000, 3'b101, 7'b0110011), 32'h80000000, 32'd4, 32'd0, 8'h00, 32'h08000000};
        v[4]  = '{"slt",  mk(7'b0000000, 3'b010, 7'b0110011), 32'hFFFFFFFF, 32'd1, 32'd0, 8'h00, 32'd1};
        v[5]  = '{"sltu", mk(7'b0000000, 3'b011, 7'b0110011), 32'hFFFFFFFF, 32'd1, 32'd0, 8'h00, 32'd0};
        v[6]  = '{"xor",  mk(7'b0000000, 3'b100, 7'b0110011), 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 8'h00, 32'hF0F0F0F0};
        v[7]  = '{"or",   mk(7'b0000000, 3'b110, 7'b0110011), 32'hF0, 32'h0F, 32'd0, 8'h00, 32'hFF};
        v[8]  = '{"and",  mk(7'b0000000, 3'b111, 7'b0110011), 32'hF0, 32'h3C, 32'd0, 8'h00, 32'h30};
        v[9]  = '{"addi", mk(7'b0000000, 3'b000, 7'b0010011), 32'hFFFFFFFF, 32'd5, 32'd100, 8'h02, 32'd99};
        v[10] = '{"wrap", mk(7'b0000000, 3'b000, 7'b0110011), 32'hFFFFFFFF, 32'd2, 32'd0, 8'h00, 32'd1};
        for (int i = 0; i < 11; i++) begin
            RD_Instr = v[i].ins; RD1 = v[i].a; RD2 = v[i].b; Imm_Ext = v[i].imm; contrl_sig = v[i].ctl;
            tick();
            checks++;
            if (ALUResult !== v[i].exp) begin
                errors++; $display("FAIL alu_%s got %h want %h", v[i].name, ALUResult, v[i].exp);
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] ins;
        ins = mk(7'd0, 3'b010, 7'b0100011);
        RD_Instr = ins; RD1 = 32'h100; RD2 = 32'hDEADBEEF; Imm_Ext = 8; contrl_sig = 8'h06;
        tick();
        checks++; if (ALUResult !== 32'h108) begin errors++; $display("FAIL store_addr got %h want 108", ALUResult); end
        checks++; if (RD2_Top !== 32'hDEADBEEF) begin errors++; $display("FAIL store_data got %h want deadbeef", RD2_Top); end
        checks++; if (ctrl_sig[2] !== 1'b1) begin errors++; $display("FAIL store_memwrite got %b want 1", ctrl_sig[2]); end
        checks++; if (next_IR !== ins) begin errors++; $display("FAIL store_ir got %h want %h", next_IR, ins); end
    endtask

    task automatic test_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] ins;
        int busy_cnt;
        int bad_ctrl;
        ins = mk(7'b0000001, f3, 7'b0110011);
        RD_Instr = ins; RD1 = a; RD2 = b; Imm_Ext = 32'h55; contrl_sig = 8'h81;
        #1;
        busy_cnt = 0;
        bad_ctrl = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_present got %b want 1", name, busy); end
        if (busy === 1'b1) busy_cnt++;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 1) begin
                RD1 = $urandom; RD2 = $urandom; Imm_Ext = $urandom;
                contrl_sig = 8'($urandom); RD_Instr = $urandom;
            end
            if (k <= 33 && busy === 1'b1) busy_cnt++;
            if (k <= 33 && ctrl_sig !== 8'd0) bad_ctrl++;
        end
        checks++; if (ALUResult !== exp) begin errors++; $display("FAIL %s_result got %h want %h", name, ALUResult, exp); end
        checks++; if (busy_cnt !== 33) begin errors++; $display("FAIL %s_busy_cycles got %0d want 33", name, busy_cnt); end
        checks++; if (bad_ctrl !== 0) begin errors++; $display("FAIL %s_bubble got %0d nonzero ctrl cycles want 0", name, bad_ctrl); end
        checks++; if (ctrl_sig !== 8'h81) begin errors++; $display("FAIL %s_ctrl got %h want 81", name, ctrl_sig); end
        checks++; if (next_IR !== ins || RD2_Top !== b) begin
            errors++; $display("FAIL %s_latched got ir %h rd2 %h want ir %h rd2 %h", name, next_IR, RD2_Top, ins, b);
        end
        set_nop();
        tick();
    endtask

    task automatic test_reset_abort();
        logic [31:0] add_ins;
        add_ins = mk(7'd0, 3'b000, 7'b0110011);
        RD_Instr = mk(7'b0000001, 3'b100, 7'b0110011); RD1 = 100; RD2 = 7; contrl_sig = 8'h11;
        for (int k = 0; k < 11; k++) tick();
        rst = 1'b1;
        RD_Instr = add_ins; RD1 = 1; RD2 = 1; Imm_Ext = 0; contrl_sig = 8'h00;
        tick();
        checks++; if (ALUResult !== 0 || RD2_Top !== 0 || next_IR !== 0 || ctrl_sig !== 0) begin
            errors++; $display("FAIL abort_outputs got %h %h %h %h want zeros", ALUResult, RD2_Top, next_IR, ctrl_sig);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        rst = 1'b0;
        tick();
        checks++; if (ALUResult !== 32'sd2) begin errors++; $display("FAIL abort_add got %h want 2", ALUResult); end
        for (int k = 0; k < 30; k++) tick();
        checks++; if (ALUResult !== 32'sd2 || next_IR !== add_ins) begin
            errors++; $display("FAIL abort_no_result got %h ir %h want 2 ir %h", ALUResult, next_IR, add_ins);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_nop();
        test_reset();
        test_add();
        test_alu_ops();
        test_store();
        test_mop("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        test_mop("mul",      3'b000, 32'd3,        32'd4,        32'd12);
        test_mop("mul_neg",  3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1);
        test_mop("mulh",     3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF);
        test_mop("mulhsu",   3'b010, 32'h80000000, 32'd2,        32'hFFFFFFFF);
        test_mop("div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        test_mop("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        test_mop("div_negd", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
        test_mop("rem_negd", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1);
        test_mop("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        test_mop("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        test_mop("divu_z",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF);
        test_mop("remu_z",   3'b111, 32'd5,        32'd0,        32'd5);
        test_mop("div_z",    3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk2  in  1  stage clock, all state on posedge
- rst  in  1  synchronous active-high reset
- RD1  in  32 signed  rs1 operand from decode
- RD2  in  32 signed  rs2 operand from decode
- Imm_Ext  in  32 signed  sign-extended immediate
- RD_Instr  in  32  instruction word in execute
- contrl_sig  in  8  control bundle; bit[2]=MemWrite, bit[1]=ALUSrc (1=Imm_Ext), others pass through
- ALUResult  out  32 signed  registered result/address to memory stage
- RD2_Top  out  32 signed  registered store data (RD2)
- next_IR  out  32  registered instruction word
- ctrl_sig  out  8  registered control bundle
- busy  out  1  upstream SHALL hold all inputs stable while high

Function
REQ-003 SHALL decode from RD_Instr[6:0], [14:12], [31:25]: OP (0110011), OP-IMM (0010011), LOAD (0000011), STORE (0100011); any other opcode SHALL compute RD1+operand B.
REQ-004 Operand B SHALL be Imm_Ext if contrl_sig[1]=1, else RD2.
REQ-005 Single-cycle ops: ADD/SUB (SUB only OP with funct7=0100000), SLL/SRL/SRA (shamt = B[4:0]), SLT (signed), SLTU, XOR, OR, AND; LOAD/STORE SHALL compute RD1+Imm_Ext; results wrap mod 2^32.
REQ-006 Single-cycle ops SHALL register ALUResult, RD2_Top, next_IR, ctrl_sig on the next posedge (latency 1), busy=0.
REQ-007 M-ops (OP, funct7=0000001): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU SHALL execute in a multi-cycle FSM: IDLE, CALC, DONE.
REQ-008 IDLE with M-op presented: busy=1 combinationally; at posedge latch RD1, RD2, RD_Instr, contrl_sig, funct3; clear 5-bit counter; go CALC; register ctrl_sig=0 (bubble).
REQ-009 CALC: busy=1; one shift-add (mul) or restoring-subtract (div) step per cycle; counter 0..31; at counter=31 go DONE; ctrl_sig output SHALL stay 0.
REQ-010 DONE: busy=0; at posedge register result with the latched RD_Instr, contrl_sig, RD2; go IDLE. Total latency: 34 posedges from presentation to result on outputs.
REQ-011 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU product[63:32] with ss/su/uu operand signedness.
REQ-012 Divide by zero: DIV/DIVU quotient = 32'hFFFFFFFF; REM/REMU = dividend; full 34-cycle latency retained.
REQ-013 Signed overflow (DIV/REM of 32'h80000000 by -1): quotient 32'h80000000, remainder 0; full latency.
REQ-014 Signed DIV SHALL truncate toward zero; REM sign SHALL follow dividend.
REQ-015 Input changes during CALC/DONE SHALL be ignored (operands latched).
REQ-016 In DONE, a following M-op SHALL be accepted only after return to IDLE (no back-to-back overlap); next instruction presented in IDLE.

Reset
REQ-017 rst at posedge SHALL force state=IDLE, counter=0, ALUResult=0, RD2_Top=0, next_IR=0, ctrl_sig=0; busy=0 the following cycle.
REQ-018 rst during CALC/DONE SHALL abort the operation with no result emitted; rst has priority over all events.

Structure
REQ-019 Opcode, funct3, funct7 constants, ctrl_sig bit indices and FSM state encoding SHALL live in shared package rv_pkg.
REQ-020 Iterative multiply/divide datapath SHALL be sub-module md_unit (start, op, operands in; done, 32-bit result out); ALU and output registers stay in execute_stage.

Verification
REQ-021 ADD: RD1=5, RD2=-7, ALUSrc=0 -> ALUResult=-2 after 1 posedge, busy=0.
REQ-022 STORE: RD1=0x100, Imm_Ext=8, RD2=0xDEADBEEF, contrl_sig[2]=1 -> ALUResult=0x108, RD2_Top=0xDEADBEEF, ctrl_sig[2]=1 after 1 posedge.
REQ-023 MULHU 0xFFFFFFFF*0xFFFFFFFF -> busy high 33 cycles, ctrl_sig=0 meanwhile, ALUResult=0xFFFFFFFE on 34th posedge.
REQ-024 DIV -7/2 -> quotient -3; REM -7/2 -> -1; DIV 0x80000000/-1 -> 0x80000000; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; each 34-cycle latency.
REQ-025 rst asserted at CALC counter=10 -> next cycle all outputs 0, busy=0; subsequent ADD 1+1 -> 2 after 1 posedge.
REQ-026 Operands changed to random values during CALC of MUL 3*4 -> ALUResult=12.
